spart_rx_buffered: RTL and testbench

//  Parametrised SPART receiver: oversampled-free mid-bit sampling UART RX with selectable baud,

---
 rtl/spart_pkg.sv | 15 +
 rtl/spart_rx_fifo.sv | 56 +++++
 rtl/spart_rx_buffered.sv | 147 ++++++++++++++
 tb/tb_spart_rx_buffered.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/spart_pkg.sv
// Shared types and constants for the SPART receive path: FSM states and the baud divisor helper.
// No logic of its own; latency and backpressure are properties of the modules importing it.
package spart_pkg;

  localparam int BAUD_BASE = 4800;
  localparam int BR_CFG_W  = 2;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} rx_state_t;

  // Clock cycles per bit for a given baud select.
  function automatic int baud_div(input int clk_hz, input logic [BR_CFG_W-1:0] br);
    return clk_hz / (BAUD_BASE << br);
  endfunction

endpackage

// File: rtl/spart_rx_fifo.sv
// Synchronous FIFO with a registered head; the head appears on rd_data the cycle after the push or pop.
// A push into a full FIFO is dropped unless a pop happens in the same cycle. A pop from an empty FIFO is ignored.
module spart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_n;
  logic [CW-1:0]    count_n;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count != '0);
    do_push  = push && ((count != CW'(DEPTH)) || do_pop);
    rd_ptr_n = rd_ptr + AW'(do_pop);
    count_n  = count + CW'(do_push) - CW'(do_pop);
  end

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr_n;
      count  <= count_n;
      // When the new head is the entry being written this cycle, bypass the memory.
      if (count_n != '0)
        rd_data <= (do_push && (wr_ptr == rd_ptr_n)) ? wr_data : mem[rd_ptr_n];
    end
  end

endmodule

// File: rtl/spart_rx_buffered.sv
// Mid-bit sampling UART receiver with RX FIFO; byte on rd_data ~1 cycle after stop sample (+2 sync); full FIFO drops with overrun pulse.
// Optional parity bit enabled by defining SPART_RX_PARITY_EN; otherwise parity_err is tied 0.
module spart_rx_buffered
  import spart_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rxd,
  input  logic [BR_CFG_W-1:0]    br_cfg,
  input  logic                   rd_en,
  output logic [DATA_BITS-1:0]   rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy,
  output logic                   frame_err,
  output logic                   overrun,
  output logic                   parity_err
);

  localparam int CNT_W = $clog2(CLK_HZ / BAUD_BASE + 1);
  localparam int BIT_W = $clog2(DATA_BITS);

  rx_state_t            state;
  logic                 rxd_m, rxd_s;
  logic [CNT_W-1:0]     div_q, baud_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shreg, push_dat;
  logic                 push_q, par_bad;
  logic                 tick;

  assign tick = (baud_cnt == div_q - CNT_W'(1));
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rxd_m      <= 1'b1;
      rxd_s      <= 1'b1;
      div_q      <= '0;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      push_dat   <= '0;
      push_q     <= 1'b0;
      par_bad    <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      rxd_m      <= rxd;
      rxd_s      <= rxd_m;
      push_q     <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= push_q && full && !rd_en;
      case (state)
        IDLE: begin
          if (!rxd_s) begin
            div_q    <= CNT_W'(baud_div(CLK_HZ, br_cfg));
            baud_cnt <= '0;
            state    <= START;
          end
        end
        START: begin
          // Half a bit in: confirm the start bit, which also centres later samples.
          if (baud_cnt == (div_q >> 1) - CNT_W'(1)) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            par_bad  <= 1'b0;
            state    <= rxd_s ? IDLE : DATA;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (tick) begin
            baud_cnt <= '0;
            shreg    <= {rxd_s, shreg[DATA_BITS-1:1]};
            if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
`ifdef SPART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
`ifdef SPART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            baud_cnt   <= '0;
            par_bad    <= ^{shreg, rxd_s};
            parity_err <= ^{shreg, rxd_s};
            state      <= STOP;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
`endif
        STOP: begin
          if (tick) begin
            baud_cnt <= '0;
            if (rxd_s) begin
              push_q   <= !par_bad;
              push_dat <= shreg;
              state    <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BRK;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        BRK: begin
          if (rxd_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  spart_rx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push_q),
    .wr_data (push_dat),
    .pop     (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .count   (count)
  );

endmodule

// File: tb/tb_spart_rx_buffered.sv
// Directed bench for spart_rx_buffered; clock scaled so divisors are 256/128/64/32 cycles per bit.
module tb_spart_rx_buffered;

  localparam int CLK_HZ = 1_228_800;
  localparam int DIV0   = 256;
  localparam int DIV1   = 128;
  localparam int DIV3   = 32;
`ifdef SPART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  localparam int PE_EXP = 1;
`else
  localparam bit PAR_EN = 1'b0;
  localparam int PE_EXP = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rxd;
  logic [1:0] br_cfg;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty, full, busy, frame_err, overrun, parity_err;
  logic [3:0] count;

  int n_checks = 0;
  int n_pass   = 0;
  int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;
  int fe0, ov0;

  always #5 clk = ~clk;

  spart_rx_buffered #(.CLK_HZ(CLK_HZ), .DATA_BITS(8), .DEPTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rxd        (rxd),
    .br_cfg     (br_cfg),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .busy       (busy),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  // Count cycles each pulse is high; a single 1-cycle event adds exactly one.
  always @(negedge clk) begin
    if (frame_err)  fe_cnt++;
    if (overrun)    ov_cnt++;
    if (parity_err) pe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop1();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    @(negedge clk);
  endtask

  // One frame LSB first; with sync_pop, pop in the same cycle the byte is pushed.
  task automatic send_frame(input logic [7:0] d, input int per, input logic stop,
                            input logic bad_par, input logic sync_pop);
    logic [7:0] dv;
    int k;
    dv = d;
    rxd = 1'b0;
    wait_cyc(per);
    for (int i = 0; i < 8; i++) begin
      rxd = dv[i];
      wait_cyc(per);
    end
    if (PAR_EN) begin
      rxd = (^dv) ^ bad_par;
      wait_cyc(per);
    end
    rxd = stop;
    if (sync_pop) begin
      k = 0;
      while (busy && k < per) begin
        @(negedge clk);
        k++;
      end
      check("sync_pop_busy_fall", {31'b0, busy}, 32'd0);
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      wait_cyc(per / 2);
    end else begin
      wait_cyc(per);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    rxd    = 1'b1;
    br_cfg = 2'd0;
    rd_en  = 1'b0;
    wait_cyc(5);
    check("rst_empty",   {31'b0, empty}, 32'd1);
    check("rst_full",    {31'b0, full},  32'd0);
    check("rst_count",   {28'b0, count}, 32'd0);
    check("rst_rd_data", {24'b0, rd_data}, 32'd0);
    check("rst_busy",    {31'b0, busy},  32'd0);
    rst_n = 1'b1;
    wait_cyc(3);

    // Frame 0x55 at 4800-equivalent rate.
    send_frame(8'h55, DIV0, 1'b1, 1'b0, 1'b0);
    wait_cyc(4);
    check("t1_rd_data", {24'b0, rd_data}, 32'h55);
    check("t1_count",   {28'b0, count},   32'd1);
    check("t1_busy",    {31'b0, busy},    32'd0);
    check("t1_fe",      fe_cnt, 32'd0);
    pop1();
    check("t1_pop_empty", {31'b0, empty}, 32'd1);

    // Frame 0xEC, then pop to empty.
    send_frame(8'hEC, DIV0, 1'b1, 1'b0, 1'b0);
    wait_cyc(4);
    check("t2_rd_data", {24'b0, rd_data}, 32'hEC);
    check("t2_empty",   {31'b0, empty},   32'd0);
    pop1();
    check("t2_pop_empty", {31'b0, empty}, 32'd1);
    check("t2_pop_count", {28'b0, count}, 32'd0);

    // br_cfg=1 latched at start; switching mid-frame must not disturb the frame.
    br_cfg = 2'd1;
    fork
      send_frame(8'hA3, DIV1, 1'b1, 1'b0, 1'b0);
      begin
        wait_cyc(DIV1 + 10);
        br_cfg = 2'd3;
      end
    join
    wait_cyc(4);
    check("br1_rd_data", {24'b0, rd_data}, 32'hA3);
    check("br1_count",   {28'b0, count},   32'd1);
    pop1();

    // Glitch shorter than half a bit: false start.
    br_cfg = 2'd0;
    rxd = 1'b0;
    wait_cyc(30);
    check("t3_busy_during", {31'b0, busy}, 32'd1);
    wait_cyc(30);
    rxd = 1'b1;
    wait_cyc(200);
    check("t3_busy_after", {31'b0, busy},  32'd0);
    check("t3_count",      {28'b0, count}, 32'd0);
    check("t3_fe",         fe_cnt, 32'd0);

    // Stop bit 0: frame error, stays in break until line returns high.
    send_frame(8'h3C, DIV0, 1'b0, 1'b0, 1'b0);
    wait_cyc(2 * DIV0);
    check("t4_fe_pulse", fe_cnt, 32'd1);
    check("t4_count",    {28'b0, count}, 32'd0);
    check("t4_brk_busy", {31'b0, busy},  32'd1);
    rxd = 1'b1;
    wait_cyc(8);
    check("t4_idle_busy", {31'b0, busy}, 32'd0);

    // Fill to full at br_cfg=3, overrun on the 9th frame.
    br_cfg = 2'd3;
    ov0 = ov_cnt;
    for (int i = 1; i <= 8; i++) send_frame(8'(i), DIV3, 1'b1, 1'b0, 1'b0);
    wait_cyc(4);
    check("t5_full",     {31'b0, full},  32'd1);
    check("t5_count8",   {28'b0, count}, 32'd8);
    check("t5_no_ov",    ov_cnt - ov0,   32'd0);
    send_frame(8'h09, DIV3, 1'b1, 1'b0, 1'b0);
    wait_cyc(4);
    check("t5_ov_pulse", ov_cnt - ov0,   32'd1);
    check("t5_count_ov", {28'b0, count}, 32'd8);
    check("t5_head",     {24'b0, rd_data}, 32'h01);
    send_frame(8'h0A, DIV3, 1'b1, 1'b0, 1'b1);
    wait_cyc(4);
    check("t5_pp_count", {28'b0, count}, 32'd8);
    check("t5_pp_no_ov", ov_cnt - ov0,   32'd1);
    for (int i = 2; i <= 8; i++) begin
      check($sformatf("t5_pop_%0d", i), {24'b0, rd_data}, 32'(i));
      pop1();
    end
    check("t5_pop_last", {24'b0, rd_data}, 32'h0A);
    pop1();
    check("t5_drained", {31'b0, empty}, 32'd1);

    // Reset mid-frame flushes FIFO and abandons the frame.
    send_frame(8'h77, DIV3, 1'b1, 1'b0, 1'b0);
    wait_cyc(4);
    check("rstm_count_pre", {28'b0, count}, 32'd1);
    rxd = 1'b0;
    wait_cyc(3 * DIV3);
    rst_n = 1'b0;
    wait_cyc(2);
    rst_n = 1'b1;
    rxd = 1'b1;
    @(negedge clk);
    check("rstm_busy",  {31'b0, busy},  32'd0);
    check("rstm_empty", {31'b0, empty}, 32'd1);
    wait_cyc(4 * DIV3);
    check("rstm_count", {28'b0, count}, 32'd0);

`ifdef SPART_RX_PARITY_EN
    fe0 = fe_cnt;
    send_frame(8'h55, DIV3, 1'b1, 1'b1, 1'b0);
    wait_cyc(4);
    check("t6_pe_pulse", pe_cnt, 32'd1);
    check("t6_no_push",  {28'b0, count}, 32'd0);
    send_frame(8'h55, DIV3, 1'b1, 1'b0, 1'b0);
    wait_cyc(4);
    check("t6_push",     {24'b0, rd_data}, 32'h55);
    check("t6_count",    {28'b0, count},   32'd1);
    check("t6_fe",       fe_cnt - fe0,     32'd0);
`endif
    check("pe_total", pe_cnt, 32'(PE_EXP));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
